// File: rtl/reservation_station.sv
// reservation_station: RS_DEPTH-entry issue buffer with CDB wakeup, oldest-ready select and a
// registered valid/stall issue port. Define PROCYON_RS_PERF_CNT_EN to add o_rs_full_cycles.
module reservation_station #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int OPCODE_WIDTH = 5,
  parameter int RS_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_rs_en,
  input  logic [OPCODE_WIDTH-1:0]   i_rs_opcode,
  input  logic [ADDR_WIDTH-1:0]     i_rs_pc,
  input  logic [DATA_WIDTH-1:0]     i_rs_insn,
  input  logic [TAG_WIDTH-1:0]      i_rs_dst_tag,
  input  logic [1:0]                i_rs_src_rdy,
  input  logic [2*DATA_WIDTH-1:0]   i_rs_src_data,
  input  logic [2*TAG_WIDTH-1:0]    i_rs_src_tag,
  input  logic                      i_cdb_en,
  input  logic [TAG_WIDTH-1:0]      i_cdb_tag,
  input  logic [DATA_WIDTH-1:0]     i_cdb_data,
  output logic                      o_rs_stall,
`ifdef PROCYON_RS_PERF_CNT_EN
  output logic [31:0]               o_rs_full_cycles,
`endif
  output logic                      o_fu_valid,
  output logic [OPCODE_WIDTH-1:0]   o_fu_opcode,
  output logic [ADDR_WIDTH-1:0]     o_fu_pc,
  output logic [DATA_WIDTH-1:0]     o_fu_insn,
  output logic [DATA_WIDTH-1:0]     o_fu_src_a,
  output logic [DATA_WIDTH-1:0]     o_fu_src_b,
  output logic [TAG_WIDTH-1:0]      o_fu_dst_tag,
  input  logic                      i_fu_stall
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  typedef struct packed {
    logic                  rdy;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } src_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   insn;
    logic [TAG_WIDTH-1:0]    dst_tag;
    src_t [1:0]              src;
  } payload_t;

  logic [RS_DEPTH-1:0] valid_q;
  logic [IDX_W-1:0]    age_q [RS_DEPTH];
  payload_t            pay_q [RS_DEPTH];
  payload_t            enq_entry;

  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    win_age;
  logic                enq_fire;
  logic                issue_load;
  logic                issue_fire;

  assign o_rs_stall = &valid_q;
  assign enq_fire   = i_rs_en & ~o_rs_stall & ~i_flush;
  assign issue_load = ~o_fu_valid | ~i_fu_stall;
  assign issue_fire = issue_load & win_found;

  // Lowest free slot for enqueue; oldest fully-ready entry for issue (ties go to the lower index).
  always_comb begin
    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    free_found = 1'b0;
    free_idx   = '0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_age    = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (valid_q[i] && pay_q[i].src[0].rdy && pay_q[i].src[1].rdy &&
          (!win_found || age_q[i] > win_age)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_age   = age_q[i];
      end
    end
  end

  // Incoming entry, with a source picked straight off the CDB if it broadcasts this cycle.
  always_comb begin
    enq_entry.opcode  = i_rs_opcode;
    enq_entry.pc      = i_rs_pc;
    enq_entry.insn    = i_rs_insn;
    enq_entry.dst_tag = i_rs_dst_tag;
    for (int s = 0; s < 2; s++) begin
      enq_entry.src[s].rdy  = i_rs_src_rdy[s];
      enq_entry.src[s].tag  = i_rs_src_tag[s*TAG_WIDTH +: TAG_WIDTH];
      enq_entry.src[s].data = i_rs_src_data[s*DATA_WIDTH +: DATA_WIDTH];
      if (!i_rs_src_rdy[s] && i_cdb_en && i_rs_src_tag[s*TAG_WIDTH +: TAG_WIDTH] == i_cdb_tag) begin
        enq_entry.src[s].rdy  = 1'b1;
        enq_entry.src[s].data = i_cdb_data;
      end
    end
  end

  // Occupancy and age tracking.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (issue_fire && win_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b0;
        end else if (enq_fire && free_idx == IDX_W'(i)) begin
          valid_q[i] <= 1'b1;
          age_q[i]   <= '0;
        end else if (enq_fire && valid_q[i]) begin
          age_q[i]   <= age_q[i] + IDX_W'(1);
        end
      end
    end
  end

  // NOTE: payload storage has no reset; it is only ever read behind a set valid bit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (enq_fire && free_idx == IDX_W'(i)) begin
        pay_q[i] <= enq_entry;
      end else if (i_cdb_en) begin
        for (int s = 0; s < 2; s++) begin
          if (!pay_q[i].src[s].rdy && pay_q[i].src[s].tag == i_cdb_tag) begin
            pay_q[i].src[s].rdy  <= 1'b1;
            pay_q[i].src[s].data <= i_cdb_data;
          end
        end
      end
    end
  end

  // Issue register: reloads whenever empty or the FU accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_fu_valid   <= 1'b0;
      o_fu_opcode  <= '0;
      o_fu_pc      <= '0;
      o_fu_insn    <= '0;
      o_fu_src_a   <= '0;
      o_fu_src_b   <= '0;
      o_fu_dst_tag <= '0;
    end else if (i_flush) begin
      o_fu_valid <= 1'b0;
    end else if (issue_load) begin
      o_fu_valid <= win_found;
      if (win_found) begin
        o_fu_opcode  <= pay_q[win_idx].opcode;
        o_fu_pc      <= pay_q[win_idx].pc;
        o_fu_insn    <= pay_q[win_idx].insn;
        o_fu_src_a   <= pay_q[win_idx].src[0].data;
        o_fu_src_b   <= pay_q[win_idx].src[1].data;
        o_fu_dst_tag <= pay_q[win_idx].dst_tag;
      end
    end
  end

`ifdef PROCYON_RS_PERF_CNT_EN
  // Saturating count of full cycles; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rs_full_cycles <= '0;
    end else if (o_rs_stall && o_rs_full_cycles != '1) begin
      o_rs_full_cycles <= o_rs_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: vector table, directed corner sequences and a randomized run,
// all shadowed every cycle by a slot/sequence-number reference model.
module tb_reservation_station;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TW = 6;
  localparam int OW = 5;
  localparam int D  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            rs_en;
  logic [OW-1:0]   rs_opcode;
  logic [AW-1:0]   rs_pc;
  logic [DW-1:0]   rs_insn;
  logic [TW-1:0]   rs_dst_tag;
  logic [1:0]      rs_src_rdy;
  logic [2*DW-1:0] rs_src_data;
  logic [2*TW-1:0] rs_src_tag;
  logic            cdb_en;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic            fu_stall;
  logic            rs_stall;
  logic            fu_valid;
  logic [OW-1:0]   fu_opcode;
  logic [AW-1:0]   fu_pc;
  logic [DW-1:0]   fu_insn;
  logic [DW-1:0]   fu_src_a;
  logic [DW-1:0]   fu_src_b;
  logic [TW-1:0]   fu_dst_tag;

  reservation_station #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .OPCODE_WIDTH(OW), .RS_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_rs_en(rs_en), .i_rs_opcode(rs_opcode),
    .i_rs_pc(rs_pc), .i_rs_insn(rs_insn), .i_rs_dst_tag(rs_dst_tag), .i_rs_src_rdy(rs_src_rdy),
    .i_rs_src_data(rs_src_data), .i_rs_src_tag(rs_src_tag), .i_cdb_en(cdb_en),
    .i_cdb_tag(cdb_tag), .i_cdb_data(cdb_data), .o_rs_stall(rs_stall), .o_fu_valid(fu_valid),
    .o_fu_opcode(fu_opcode), .o_fu_pc(fu_pc), .o_fu_insn(fu_insn), .o_fu_src_a(fu_src_a),
    .o_fu_src_b(fu_src_b), .o_fu_dst_tag(fu_dst_tag), .i_fu_stall(fu_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] opcode;
    logic [AW-1:0] pc;
    logic [DW-1:0] insn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] dst;
  } fu_t;

  typedef struct packed {
    bit                 valid;
    int                 seq;
    logic [OW-1:0]      opcode;
    logic [AW-1:0]      pc;
    logic [DW-1:0]      insn;
    logic [TW-1:0]      dst;
    logic [1:0]         rdy;
    logic [1:0][TW-1:0] tag;
    logic [1:0][DW-1:0] data;
  } m_entry_t;

  typedef struct {
    logic [OW-1:0] op;
    logic [TW-1:0] dst;
    logic [1:0]    rdy;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag_a;
    logic [TW-1:0] tag_b;
    bit            cdb;
    logic [TW-1:0] cdb_t;
    logic [DW-1:0] cdb_d;
    bit            exp_issue;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  fu_t      dut_fu;
  fu_t      m_fu;
  m_entry_t m_e [D];
  bit       m_fu_valid;
  int       m_cnt;
  int       n_checks = 0;
  int       n_errors = 0;
  vec_t     vecs [6];

  assign dut_fu = {fu_opcode, fu_pc, fu_insn, fu_src_a, fu_src_b, fu_dst_tag};

  task check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task model_clear();
    for (int i = 0; i < D; i++) m_e[i] = '0;
    m_fu_valid = 1'b0;
    m_fu       = '0;
    m_cnt      = 0;
  endtask

  // Age of an entry = number of accepted enqueues since it arrived, kept in log2(D) bits.
  task model_step();
    int  win, best, fr, age;
    bit  full;
    if (flush) begin
      for (int i = 0; i < D; i++) m_e[i].valid = 1'b0;
      m_fu_valid = 1'b0;
      return;
    end
    full = 1'b1;
    win  = -1;
    best = -1;
    fr   = -1;
    for (int i = 0; i < D; i++) begin
      if (!m_e[i].valid) begin
        full = 1'b0;
        if (fr < 0) fr = i;
      end else if (m_e[i].rdy == 2'b11) begin
        age = (m_cnt - m_e[i].seq) % D;
        if (age > best) begin
          best = age;
          win  = i;
        end
      end
    end
    if (!m_fu_valid || !fu_stall) begin
      m_fu_valid = (win >= 0);
      if (win >= 0) begin
        m_fu = {m_e[win].opcode, m_e[win].pc, m_e[win].insn, m_e[win].data[0],
                m_e[win].data[1], m_e[win].dst};
        m_e[win].valid = 1'b0;
      end
    end
    if (cdb_en) begin
      for (int i = 0; i < D; i++)
        for (int s = 0; s < 2; s++)
          if (m_e[i].valid && !m_e[i].rdy[s] && m_e[i].tag[s] == cdb_tag) begin
            m_e[i].rdy[s]  = 1'b1;
            m_e[i].data[s] = cdb_data;
          end
    end
    if (rs_en && !full) begin
      m_cnt++;
      m_e[fr].valid  = 1'b1;
      m_e[fr].seq    = m_cnt;
      m_e[fr].opcode = rs_opcode;
      m_e[fr].pc     = rs_pc;
      m_e[fr].insn   = rs_insn;
      m_e[fr].dst    = rs_dst_tag;
      for (int s = 0; s < 2; s++) begin
        m_e[fr].rdy[s]  = rs_src_rdy[s];
        m_e[fr].tag[s]  = rs_src_tag[s*TW +: TW];
        m_e[fr].data[s] = rs_src_data[s*DW +: DW];
        if (!rs_src_rdy[s] && cdb_en && rs_src_tag[s*TW +: TW] == cdb_tag) begin
          m_e[fr].rdy[s]  = 1'b1;
          m_e[fr].data[s] = cdb_data;
        end
      end
    end
  endtask

  task model_check();
    bit full;
    full = 1'b1;
    for (int i = 0; i < D; i++) if (!m_e[i].valid) full = 1'b0;
    check("model_stall", rs_stall, full);
    check("model_fu_valid", fu_valid, m_fu_valid);
    if (m_fu_valid) check("model_fu_data", dut_fu, m_fu);
  endtask

  task tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task idle();
    rs_en  = 1'b0;
    cdb_en = 1'b0;
    flush  = 1'b0;
  endtask

  task enq(input logic [OW-1:0] op, input logic [TW-1:0] dst, input logic [1:0] rdy,
           input logic [DW-1:0] a, input logic [DW-1:0] b,
           input logic [TW-1:0] ta, input logic [TW-1:0] tgb);
    rs_en       = 1'b1;
    rs_opcode   = op;
    rs_pc       = $urandom;
    rs_insn     = $urandom;
    rs_dst_tag  = dst;
    rs_src_rdy  = rdy;
    rs_src_data = {b, a};
    rs_src_tag  = {tgb, ta};
  endtask

  task do_flush();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    vecs[0] = '{op:3, dst:5, rdy:2'b11, a:'h10, b:'h20, tag_a:0, tag_b:0, cdb:0, cdb_t:0,
                cdb_d:0, exp_issue:1, exp_a:'h10, exp_b:'h20};
    vecs[1] = '{op:1, dst:6, rdy:2'b10, a:'h0, b:'h22, tag_a:4, tag_b:0, cdb:1, cdb_t:4,
                cdb_d:'h55, exp_issue:1, exp_a:'h55, exp_b:'h22};
    vecs[2] = '{op:2, dst:7, rdy:2'b00, a:'h0, b:'h0, tag_a:4, tag_b:4, cdb:1, cdb_t:4,
                cdb_d:'h77, exp_issue:1, exp_a:'h77, exp_b:'h77};
    vecs[3] = '{op:4, dst:8, rdy:2'b01, a:'h1, b:'h0, tag_a:0, tag_b:8, cdb:1, cdb_t:9,
                cdb_d:'h99, exp_issue:0, exp_a:'h0, exp_b:'h0};
    vecs[4] = '{op:5, dst:9, rdy:2'b11, a:'h1, b:'h2, tag_a:3, tag_b:0, cdb:1, cdb_t:3,
                cdb_d:'h99, exp_issue:1, exp_a:'h1, exp_b:'h2};
    vecs[5] = '{op:6, dst:10, rdy:2'b00, a:'h0, b:'h0, tag_a:2, tag_b:2, cdb:0, cdb_t:2,
                cdb_d:'h33, exp_issue:0, exp_a:'h0, exp_b:'h0};

    rst = 1'b1;
    fu_stall = 1'b0;
    rs_opcode = '0; rs_pc = '0; rs_insn = '0; rs_dst_tag = '0;
    rs_src_rdy = '0; rs_src_data = '0; rs_src_tag = '0; cdb_tag = '0; cdb_data = '0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_stall", rs_stall, 1'b0);
    check("reset_fu_valid", fu_valid, 1'b0);
    check("reset_fu_data", dut_fu, '0);
    rst = 1'b0;

    // Single-entry vectors: enqueue (optionally with CDB bypass), check two edges later.
    for (int v = 0; v < 6; v++) begin
      enq(vecs[v].op, vecs[v].dst, vecs[v].rdy, vecs[v].a, vecs[v].b, vecs[v].tag_a, vecs[v].tag_b);
      cdb_en = vecs[v].cdb; cdb_tag = vecs[v].cdb_t; cdb_data = vecs[v].cdb_d;
      tick();
      check($sformatf("vec%0d_early", v), fu_valid, 1'b0);
      idle();
      tick();
      check($sformatf("vec%0d_valid", v), fu_valid, vecs[v].exp_issue);
      if (vecs[v].exp_issue) begin
        check($sformatf("vec%0d_a", v), fu_src_a, vecs[v].exp_a);
        check($sformatf("vec%0d_b", v), fu_src_b, vecs[v].exp_b);
        check($sformatf("vec%0d_dst", v), fu_dst_tag, vecs[v].dst);
        check($sformatf("vec%0d_op", v), fu_opcode, vecs[v].op);
      end
      do_flush();
    end

    // CDB wakeup of a waiting source.
    enq(1, 1, 2'b01, 'h1111, 0, 0, 9);
    tick();
    idle();
    tick();
    check("wake_pre", fu_valid, 1'b0);
    cdb_en = 1'b1; cdb_tag = 9; cdb_data = 'hABCD;
    tick();
    check("wake_cdb_edge", fu_valid, 1'b0);
    idle();
    tick();
    check("wake_valid", fu_valid, 1'b1);
    check("wake_b", fu_src_b, 32'hABCD);
    check("wake_dst", fu_dst_tag, 6'd1);
    do_flush();

    // Oldest-first under FU back-pressure.
    fu_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      enq(0, TW'(k), 2'b11, DW'(k), DW'(k), 0, 0);
      tick();
    end
    idle();
    repeat (2) tick();
    check("order_hold_valid", fu_valid, 1'b1);
    check("order_hold_dst", fu_dst_tag, 6'd1);
    fu_stall = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      tick();
      check($sformatf("order_dst%0d", k), fu_dst_tag, TW'(k));
    end
    tick();
    check("order_empty", fu_valid, 1'b0);

    // Fill to full, drop an extra enqueue, then drain oldest-first.
    for (int k = 0; k < D; k++) begin
      enq(0, TW'(10 + k), 2'b10, 0, DW'(k), 7, 0);
      tick();
    end
    check("full_stall", rs_stall, 1'b1);
    enq(0, 20, 2'b11, 1, 1, 0, 0);
    tick();
    check("full_drop_stall", rs_stall, 1'b1);
    idle();
    cdb_en = 1'b1; cdb_tag = 7; cdb_data = 'h700;
    tick();
    check("full_wake_edge", fu_valid, 1'b0);
    idle();
    tick();
    check("full_first_valid", fu_valid, 1'b1);
    check("full_first_dst", fu_dst_tag, 6'd10);
    check("full_first_a", fu_src_a, 32'h700);
    check("full_stall_drop", rs_stall, 1'b0);
    for (int k = 1; k < D; k++) begin
      tick();
      check($sformatf("full_drain%0d", k), fu_dst_tag, TW'(10 + k));
    end
    tick();
    check("full_no_extra", fu_valid, 1'b0);

    // Flush with stalled output and occupied entries.
    fu_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      enq(0, TW'(30 + k), 2'b11, 0, 0, 0, 0);
      tick();
    end
    idle();
    check("flush_pre_valid", fu_valid, 1'b1);
    check("flush_pre_dst", fu_dst_tag, 6'd30);
    flush = 1'b1;
    tick();
    check("flush_valid", fu_valid, 1'b0);
    check("flush_stall", rs_stall, 1'b0);
    flush = 1'b0;
    fu_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_no_issue", fu_valid, 1'b0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      enq(OW'($urandom), TW'($urandom_range(63)), 2'($urandom), $urandom, $urandom,
          TW'($urandom_range(7)), TW'($urandom_range(7)));
      rs_en    = ($urandom_range(9) < 6);
      cdb_en   = ($urandom_range(9) < 4);
      cdb_tag  = TW'($urandom_range(7));
      cdb_data = $urandom;
      flush    = ($urandom_range(49) == 0);
      fu_stall = ($urandom_range(9) < 3);
      tick();
    end

    // Asynchronous reset in mid-operation.
    idle();
    fu_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq(1, TW'(40 + k), 2'b11, 'h5, 'h6, 0, 0);
      tick();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst_fu_valid", fu_valid, 1'b0);
    check("arst_stall", rs_stall, 1'b0);
    check("arst_fu_data", dut_fu, '0);
    @(negedge clk);
    rst = 1'b0;
    fu_stall = 1'b0;
    model_clear();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Sits directly downstream of the map/dispatch register stage.
- Accepts one dispatched instruction per cycle, with source operands already looked up in the ROB, into a RS_DEPTH-entry buffer.
- Snoops the CDB to wake up pending operands.
- Issues the oldest entry whose operands are all ready to a functional unit, through a registered valid/stall handshake.
- Back-pressures dispatch with o_rs_stall when full.

Parameters:
- DATA_WIDTH, 32, operand/insn width
- ADDR_WIDTH, 32, PC width
- TAG_WIDTH, 6, ROB tag width
- OPCODE_WIDTH, 5, opcode width
- RS_DEPTH, 8, number of entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_flush  in  1  pipeline flush
- i_rs_en  in  1  enqueue request
- i_rs_opcode  in  OPCODE_WIDTH  opcode
- i_rs_pc  in  ADDR_WIDTH  PC
- i_rs_insn  in  DATA_WIDTH  raw instruction
- i_rs_dst_tag  in  TAG_WIDTH  destination ROB tag
- i_rs_src_rdy  in  2  per-source ready (bit0=A, bit1=B)
- i_rs_src_data  in  2xDATA_WIDTH  source values (valid when ready)
- i_rs_src_tag  in  2xTAG_WIDTH  producer tags (valid when not ready)
- i_cdb_en  in  1  CDB broadcast valid
- i_cdb_tag  in  TAG_WIDTH  CDB tag
- i_cdb_data  in  DATA_WIDTH  CDB data
- o_rs_stall  out  1  all entries valid
- o_fu_valid  out  1  issue valid
- o_fu_opcode  out  OPCODE_WIDTH
- o_fu_pc  out  ADDR_WIDTH
- o_fu_insn  out  DATA_WIDTH
- o_fu_src_a  out  DATA_WIDTH
- o_fu_src_b  out  DATA_WIDTH
- o_fu_dst_tag  out  TAG_WIDTH
- i_fu_stall  in  1  FU cannot accept

Behaviour:
- Reset (async, rst=1): all entries invalid, all ages 0, o_fu_valid=0, all o_fu_* data outputs 0.
- Entry state: valid, opcode, pc, insn, dst_tag, per-source {rdy, tag, data}, and an age field of log2(RS_DEPTH) bits.
- o_rs_stall is combinational and equals the AND of all entry valid bits. It depends on current state only, so a slot being issued this cycle does not lower stall this cycle.
- Enqueue:
  - Condition: i_rs_en & ~o_rs_stall & ~i_flush.
  - Target slot: lowest-index invalid entry.
  - Written at the edge with age=0. Every other valid entry's age increments at that edge.
  - Ages of valid entries are therefore unique and never exceed RS_DEPTH-1; no saturation logic.
  - i_rs_en while stalled is ignored; upstream holds.
- Enqueue-time CDB bypass: if i_cdb_en, source not ready and i_cdb_tag matches its tag, the source is written ready with i_cdb_data.
- Wakeup: on each edge with i_cdb_en, every valid entry source with rdy=0 and a matching tag sets rdy=1 and captures i_cdb_data. Both sources may wake in the same cycle.
- Select:
  - Candidates: valid entries with both rdy bits set in registered state.
  - A source woken this cycle is not eligible until next cycle.
  - Winner: the candidate with the largest age.
- Issue register:
  - Loads when ~o_fu_valid | ~i_fu_stall.
  - On load with a winner: o_fu_valid=1, outputs take the winner's fields, winner's valid clears at the same edge.
  - On load with no winner: o_fu_valid=0; data outputs may hold.
  - While o_fu_valid & i_fu_stall: outputs hold and no entry is freed.
- Latency: enqueue edge N with both sources ready; selected in cycle N+1; o_fu_valid high after edge N+1 (2 cycles from i_rs_en sample).
- A freed slot is reusable from the following cycle.
- Flush: takes priority over enqueue, wakeup and issue. At the edge, all entries invalid, ages 0, o_fu_valid=0.
- Mid-operation reset: immediate clear as per the reset state above.

Optional Feature:
- Macro: PROCYON_RS_PERF_CNT_EN
- Defined: adds output o_rs_full_cycles (32 bits). Increments on every clock edge where o_rs_stall=1, saturates at all-ones, cleared by rst only (not by flush).
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Enqueue opcode 3, tag 5, src A=0x10 ready, src B=0x20 ready, FU not stalled -> o_fu_valid=1 two cycles later with src_a=0x10, src_b=0x20, dst_tag=5; entry freed.
- Enqueue tag 1 with src B waiting on tag 9; two cycles later CDB tag 9 data 0xABCD -> issue one cycle after the CDB edge with src_b=0xABCD; no issue before.
- Enqueue tags 1, 2, 3 all ready on consecutive cycles with i_fu_stall=1 -> after stall drops, issue order is 1, 2, 3 on consecutive cycles.
- Fill 8 entries, all waiting on tag 7 -> o_rs_stall=1 and a 9th i_rs_en is dropped. CDB tag 7 -> 8 issues oldest-first; o_rs_stall drops the cycle after the first issue.
- Assert i_flush with 4 entries valid and o_fu_valid=1 under i_fu_stall -> next cycle o_fu_valid=0, o_rs_stall=0, no later issue.
- Enqueue with src A tag 4 not ready while CDB tag 4 data 0x55 is broadcast in the same cycle -> issue with src_a=0x55 with no further CDB.
